hex_text_buffer: RTL and testbench

- Character-cell text buffer that sits directly upstream of the VGA character generator.
- Holds a ROWS x COLS grid of 4-bit glyph codes, indexing the 16-entry hex charset (0-9, A-F).
- Display side: the char generator presents its character-cell counters and receives the glyph code one cycle later.
- Host side: a valid/ready write port accepts a 32-bit value and serialises it into hex digits at a cell position; a clear command zero-fills the grid.

---
 rtl/hex_text_buffer_pkg.sv | 23 ++
 rtl/hex_text_buffer_if.sv | 35 +++
 rtl/hex_text_buffer_text_grid_ram.sv | 23 ++
 rtl/hex_text_buffer.sv | 138 +++++++++++++
 tb/tb_hex_text_buffer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hex_text_buffer_pkg.sv
// Shared constants and types for the hex text buffer.
// Grid defaults are also used by the character generator's cell counters.
package hex_text_buffer_pkg;

  localparam int DEF_COLS  = 64;
  localparam int DEF_ROWS  = 32;
  localparam int DEF_COL_W = 6;
  localparam int DEF_ROW_W = 5;
  localparam int GLYPH_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  function automatic logic [3:0] norm_ndig(
    input logic [3:0] n
  );
    return (n == 4'd0 || n > 4'd8) ? 4'd8 : n;
  endfunction

endpackage

// File: rtl/hex_text_buffer_if.sv
// Host write/clear port and display read port of the hex text buffer.
// The host/display side uses master, the buffer uses slave.
interface hex_text_buffer_if
  import hex_text_buffer_pkg::*;
#(
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
);

  logic               wr_valid;
  logic               wr_ready;
  logic [31:0]        wr_data;
  logic [COL_W-1:0]   wr_col;
  logic [ROW_W-1:0]   wr_row;
  logic [3:0]         wr_ndig;
  logic               clr_req;
  logic               busy;
  logic [7:0]         rd_col;
  logic [7:0]         rd_row;
  logic [GLYPH_W-1:0] rd_code;
  logic               rd_valid;

  modport master (
    output wr_valid, wr_data, wr_col, wr_row,
    output wr_ndig, clr_req, rd_col, rd_row,
    input  wr_ready, busy, rd_code, rd_valid
  );

  modport slave (
    input  wr_valid, wr_data, wr_col, wr_row,
    input  wr_ndig, clr_req, rd_col, rd_row,
    output wr_ready, busy, rd_code, rd_valid
  );

endinterface

// File: rtl/hex_text_buffer_text_grid_ram.sv
// Simple dual-port glyph RAM: one write port, one registered read-first
// read port, zero contents at configuration.
module text_grid_ram #(
  parameter int AW = 11,
  parameter int DW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW] = '{default: '0};

  // Both updates are non-blocking, so a same-cell read sees old data.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/hex_text_buffer.sv
// Character-cell grid of hex glyph codes feeding the VGA char generator.
// Host writes a 32-bit value as hex digits or zero-fills the whole grid.
module hex_text_buffer
  import hex_text_buffer_pkg::*;
#(
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int COL_W = DEF_COL_W,
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic         clk,
  input  logic         rst,
  hex_text_buffer_if.slave bus
);

  localparam int AW = COL_W + ROW_W;

  state_t state, state_nx;

  logic [31:0]        sh_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [3:0]         ndig_q;
  logic [3:0]         k_q;
  logic [AW-1:0]      clr_q;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [GLYPH_W-1:0] wdata;
  logic               busy;

  logic               rd_in;
  logic [AW-1:0]      raddr;
  logic [GLYPH_W-1:0] rdata;
  logic               rd_valid_q;

  logic [3:0]         nd;
  logic [4:0]         rem;
  logic [4:0]         sh_amt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (bus.clr_req)       state_nx = CLEAR;
        else if (bus.wr_valid) state_nx = WRITE;
      end
      WRITE: begin
        if (k_q == ndig_q - 4'd1) state_nx = IDLE;
      end
      CLEAR: begin
        if (&clr_q) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset gates the write strobe so an abort never lands one more cell.
  always_comb begin
    busy  = (state != IDLE);
    we    = 1'b0;
    waddr = {row_q, col_q};
    wdata = sh_q[31:28];
    unique case (state)
      WRITE: we = ~rst;
      CLEAR: begin
        we    = ~rst;
        waddr = clr_q;
        wdata = '0;
      end
      default: ;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.wr_ready = ~busy & ~rst;

  // Left-align the value so the first digit is always the top nibble.
  always_comb begin
    nd     = norm_ndig(bus.wr_ndig);
    rem    = {1'b0, 4'd8 - nd};
    sh_amt = rem << 2;
  end

  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (!bus.clr_req && bus.wr_valid) begin
          sh_q   <= bus.wr_data << sh_amt;
          col_q  <= bus.wr_col;
          row_q  <= bus.wr_row;
          ndig_q <= nd;
          k_q    <= 4'd0;
        end
        clr_q <= '0;
      end
      WRITE: begin
        sh_q  <= sh_q << 4;
        k_q   <= k_q + 4'd1;
        col_q <= col_q + COL_W'(1);
        if (&col_q) row_q <= row_q + ROW_W'(1);
      end
      CLEAR: clr_q <= clr_q + AW'(1);
      default: ;
    endcase
  end

  assign rd_in = (int'(bus.rd_col) < COLS) &&
                 (int'(bus.rd_row) < ROWS);
  assign raddr = {bus.rd_row[ROW_W-1:0],
                  bus.rd_col[COL_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_in;
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_code  = rd_valid_q ? rdata : '0;

  text_grid_ram #(
    .AW (AW),
    .DW (GLYPH_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_hex_text_buffer.sv
// Self-checking bench for hex_text_buffer: directed table, corner
// sequences and random writes against a linear-address grid model.
module tb_hex_text_buffer;

  logic clk = 1'b0;
  logic rst;

  hex_text_buffer_if bus ();

  hex_text_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] model [2048];

  typedef struct {
    int         c;
    int         r;
    logic       v;
    logic [3:0] code;
  } rd_vec_t;

  rd_vec_t tbl [15];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int norm(input logic [3:0] nd);
    return (nd == 0 || nd > 8) ? 8 : int'(nd);
  endfunction

  task automatic model_write(input logic [31:0] d, input int c,
                             input int r, input int n);
    for (int k = 0; k < n; k++)
      model[(r * 64 + c + k) % 2048] =
        4'((d >> (4 * (n - 1 - k))) & 32'hf);
  endtask

  // Entered and left just after a falling edge.
  task automatic rd_check(input int c, input int r);
    logic       v;
    logic [3:0] code;
    bus.rd_col = 8'(c);
    bus.rd_row = 8'(r);
    @(posedge clk);
    @(negedge clk);
    v    = (c < 64 && r < 32);
    code = v ? model[r * 64 + c] : 4'h0;
    chk($sformatf("rd(%0d,%0d).valid", c, r), 32'(bus.rd_valid), 32'(v));
    chk($sformatf("rd(%0d,%0d).code", c, r), 32'(bus.rd_code), 32'(code));
  endtask

  task automatic do_write(input logic [31:0] d, input int c,
                          input int r, input logic [3:0] nd,
                          input int exp_cyc);
    int cyc;
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    bus.wr_col   = 6'(c);
    bus.wr_row   = 5'(r);
    bus.wr_ndig  = nd;
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    model_write(d, c, r, norm(nd));
    cyc = 0;
    while (!bus.wr_ready && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("wr_ready_low_cycles(%h)", d), 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    foreach (model[i]) model[i] = 4'h0;
    rst          = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.wr_col   = '0;
    bus.wr_row   = '0;
    bus.wr_ndig  = '0;
    bus.clr_req  = 1'b0;
    bus.rd_col   = '0;
    bus.rd_row   = '0;

    tbl[0]  = '{1, 3, 1'b1, 4'h0};
    tbl[1]  = '{2, 3, 1'b1, 4'h1};
    tbl[2]  = '{3, 3, 1'b1, 4'h2};
    tbl[3]  = '{4, 3, 1'b1, 4'h3};
    tbl[4]  = '{5, 3, 1'b1, 4'h4};
    tbl[5]  = '{6, 3, 1'b1, 4'hA};
    tbl[6]  = '{7, 3, 1'b1, 4'hB};
    tbl[7]  = '{8, 3, 1'b1, 4'hC};
    tbl[8]  = '{9, 3, 1'b1, 4'hD};
    tbl[9]  = '{10, 3, 1'b1, 4'h0};
    tbl[10] = '{63, 31, 1'b1, 4'h0};
    tbl[11] = '{0, 0, 1'b1, 4'hE};
    tbl[12] = '{1, 0, 1'b1, 4'hF};
    tbl[13] = '{64, 0, 1'b0, 4'h0};
    tbl[14] = '{0, 32, 1'b0, 4'h0};

    repeat (3) @(negedge clk);
    chk("reset.wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset.rd_code", 32'(bus.rd_code), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset.wr_ready", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    rd_check(0, 0);
    rd_check(64, 0);

    do_write(32'h1234ABCD, 2, 3, 4'd8, 8);
    do_write(32'h000000EF, 63, 31, 4'd3, 3);
    foreach (tbl[i]) begin
      bus.rd_col = 8'(tbl[i].c);
      bus.rd_row = 8'(tbl[i].r);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl[%0d].valid", i), 32'(bus.rd_valid), 32'(tbl[i].v));
      chk($sformatf("tbl[%0d].code", i), 32'(bus.rd_code), 32'(tbl[i].code));
    end

    // Read the cell in the same cycle it is written.
    bus.rd_col   = 8'd20;
    bus.rd_row   = 8'd5;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h7;
    bus.wr_col   = 6'd20;
    bus.wr_row   = 5'd5;
    bus.wr_ndig  = 4'd1;
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rdw.old", 32'(bus.rd_code), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rdw.new", 32'(bus.rd_code), 32'h7);
    chk("rdw.busy", 32'(bus.busy), 32'd0);
    model[5 * 64 + 20] = 4'h7;

    do_write(32'h89ABCDEF, 30, 7, 4'd0, 8);
    chk("ndig0.model_first", 32'(model[7 * 64 + 30]), 32'h8);
    for (int k = 0; k < 8; k++) rd_check(30 + k, 7);

    // Clear wins over a simultaneous write; writes are ignored mid-clear.
    bus.clr_req  = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'hFFFFFFFF;
    bus.wr_col   = 6'd40;
    bus.wr_row   = 5'd9;
    bus.wr_ndig  = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.clr_req  = 1'b0;
    bus.wr_valid = 1'b0;
    cyc = 0;
    while (bus.busy && cyc < 3000) begin
      cyc++;
      if (cyc == 100) bus.wr_valid = 1'b1;
      if (cyc == 101) bus.wr_valid = 1'b0;
      @(negedge clk);
    end
    chk("clear.busy_cycles", 32'(cyc), 32'd2048);
    foreach (model[i]) model[i] = 4'h0;
    rd_check(2, 3);
    rd_check(0, 0);
    rd_check(20, 5);
    rd_check(30, 7);
    for (int k = 0; k < 8; k++) rd_check(40 + k, 9);

    // Abort an 8-digit write with reset in its fourth cycle.
    do_write(32'hFFFFFFFF, 10, 10, 4'd8, 8);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 32'h87654321;
    bus.wr_col   = 6'd10;
    bus.wr_row   = 5'd10;
    bus.wr_ndig  = 4'd8;
    @(posedge clk);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.wr_ready_in_rst", 32'(bus.wr_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort.wr_ready_after", 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    model[10 * 64 + 10] = 4'h8;
    model[10 * 64 + 11] = 4'h7;
    model[10 * 64 + 12] = 4'h6;
    for (int k = 0; k < 8; k++) rd_check(10 + k, 10);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] d;
      logic [3:0]  nd;
      int c, r, n, lin;
      d  = $urandom;
      c  = $urandom_range(0, 63);
      r  = $urandom_range(0, 31);
      nd = 4'($urandom_range(0, 15));
      n  = norm(nd);
      do_write(d, c, r, nd, n);
      for (int k = 0; k < n; k++) begin
        lin = (r * 64 + c + k) % 2048;
        rd_check(lin % 64, lin / 64);
      end
      for (int j = 0; j < 3; j++)
        rd_check($urandom_range(0, 70), $urandom_range(0, 35));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
